fas_freq_detect: RTL and testbench
==================================

Name: fas_freq_detect

Overview:
- Downstream stage of the FIR + 16-point FFT datapath inside the frequency analysis system. It consumes the 16 FFT bins and drives the system-level done/freq outputs.
- On each new FFT frame it latches all 16 bins and scans them one bin per cycle, computing the squared magnitude re^2 + im^2 of each.
- It reports the index of the largest-magnitude bin on freq and pulses done for one cycle.

Parameters:
- DW, 16, width of each real/imag half of a bin word.
- MW, 2*DW+1 (33), width of the squared-magnitude accumulator/compare path.
- NB, 16, number of bins. Fixed; freq is log2(NB) = 4 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fft_valid  in  1  level from FFT stage; a new frame is signalled by its 0->1 transition.
- fft_d0..fft_d15  in  32 each  bin k = {real[31:16], imag[15:0]}, both two's-complement DW-bit.
- done  out  1  one-cycle pulse: freq holds a new result.
- freq  out  4  index of the max-|X|^2 bin of the last completed frame.
- busy  out  1  high while a frame is latched and being scanned.

Behaviour:
- Reset (async, while rst=1) clears all of these:
  - state=IDLE, done=0, freq=0, busy=0.
  - fft_valid_d=0, idx=0, max_mag=0, best=0.
  - Bin buffer cleared to 0.
- Frame start (start = fft_valid & ~fft_valid_d, sampled at a clk edge) does the following at that edge:
  - Latch all 16 fft_dk into buf[k].
  - Set idx=0, max_mag=0, best=0, state=SCAN, busy=1.
- fft_valid held high for many cycles produces exactly one start. A start coincident with the rst deassertion edge is not taken, because fft_valid_d is still reset-low only after that edge.
- SCAN state, one bin per cycle:
  - mag = re*re + im*im, with signed DW x DW products sign-extended to MW and summed unsigned. The maximum is 2^31 (re = im = -32768), so it never overflows.
  - If mag > max_mag (strict), then max_mag <= mag and best <= idx. Ties keep the lower index.
  - idx increments each cycle. When idx==NB-1 the compare is performed, then state=DONE.
- DONE state, one cycle:
  - freq <= best (using the value including bin 15's compare), done <= 1, busy <= 0, state=IDLE.
  - done is high for exactly one cycle; freq is held until the next completed frame.
- Latency: done is high in the 18th cycle after the start edge. Start sampled at edge E0 gives bins 0..15 compared at E1..E16, and done/freq registered at E17.
- An all-zero frame gives freq=0 with done pulsed normally.
- A start during SCAN or DONE aborts the current frame:
  - No done is issued for the aborted frame, and freq is unchanged.
  - The new bins are latched and the scan restarts at idx=0, so the newest frame wins.
- A start in the same cycle that DONE completes is the same case as the abort rule: the abort takes priority, no done is issued, and the new scan starts.
- Asserting rst mid-SCAN immediately returns the block to reset values; a pending result is discarded.
- No combinational path runs from inputs to outputs; all outputs are registered.

Decomposition:
- Shared include file holds:
  - State encodings IDLE/SCAN/DONE (2-bit localparams).
  - DW, NB and MW constants.
  - Bin-word field slicing macros (real = [31:16], imag = [15:0]).
- One sub-module, fas_mag_sq:
  - Combinational; input is a 32-bit bin word, output is the MW-bit unsigned re^2 + im^2.
  - Instantiated once and fed by buf[idx].

Test Plan:
- Reset, then one frame with all bins 0 except fft_d5 = {16'h0100, 16'h0000}: freq=5, done high exactly 18 cycles after the start edge, busy high 17 cycles.
- Tie: fft_d3 = {16'h0000, 16'h0200}, fft_d9 = {16'hFE00, 16'h0000}, others 0: equal magnitudes, freq=3 (lowest index wins).
- Extremes: fft_d15 = {16'h8000, 16'h8000}, fft_d0 = {16'h7FFF, 16'h7FFF}, others 0: 2^31 > 2*32767^2 with no overflow, so freq=15.
- fft_valid held high 100 cycles after a start: exactly one done. fft_valid then low for 1 cycle and high again: a second done, whose freq reflects the new bins.
- Second start issued 8 cycles into a scan (first frame peak at bin 2, second at bin 11): only one done, 18 cycles after the second start, freq=11.
- rst pulsed asynchronously (mid-cycle) at scan cycle 10: done/freq/busy clear immediately, no done follows. A subsequent frame with peak at bin 7 gives freq=7.

Source files
------------

// File: rtl/fas_freq_detect_pkg.sv
// Shared constants, state encodings and bin-word field helpers for the
// frequency-detect stage that follows the 16-point FFT.
package fas_freq_detect_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2 * DW;
  localparam int unsigned MW = 2 * DW + 1;
  localparam int unsigned NB = 16;
  localparam int unsigned IW = $clog2(NB);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bin word layout: real half in the upper DW bits, imaginary in the lower.
  function automatic logic signed [DW-1:0] bin_re(input logic [BW-1:0] w);
    return w[BW-1:DW];
  endfunction

  function automatic logic signed [DW-1:0] bin_im(input logic [BW-1:0] w);
    return w[DW-1:0];
  endfunction

endpackage

// File: rtl/fas_freq_detect_if.sv
// FFT-bin input bundle and done/freq/busy result signals of the detector.
interface fas_freq_detect_if;
  import fas_freq_detect_pkg::*;

  logic          fft_valid;
  logic [BW-1:0] fft_d [NB];
  logic          done;
  logic [IW-1:0] freq;
  logic          busy;

  modport master (
    output fft_valid, fft_d,
    input  done, freq, busy
  );

  modport slave (
    input  fft_valid, fft_d,
    output done, freq, busy
  );

endinterface

// File: rtl/fas_mag_sq.sv
// Squared magnitude re^2 + im^2 of one FFT bin word (combinational).
module fas_mag_sq
  import fas_freq_detect_pkg::*;
(
  input  logic [BW-1:0] bin_word,
  output logic [MW-1:0] mag
);

  logic signed [DW-1:0] re;
  logic signed [DW-1:0] im;
  logic signed [BW-1:0] re2;
  logic signed [BW-1:0] im2;

  always_comb begin
    re  = bin_re(bin_word);
    im  = bin_im(bin_word);
    re2 = re * re;
    im2 = im * im;
    // Largest result is 2^31 for re = im = -32768, so MW bits never overflow.
    mag = {re2[BW-1], re2} + {im2[BW-1], im2};
  end

endmodule

// File: rtl/fas_freq_detect.sv
// Latches an FFT frame on the rising edge of fft_valid, scans one bin per
// cycle for the largest |X|^2, and reports its index on freq with a done pulse.
module fas_freq_detect
  import fas_freq_detect_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  fas_freq_detect_if.slave bus
);

  logic [1:0]    state_q, state_d;
  logic          fft_valid_dly_q, fft_valid_dly_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] best_q, best_d;
  logic [IW-1:0] freq_q, freq_d;
  logic [MW-1:0] max_mag_q, max_mag_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [BW-1:0] bin_q [NB];
  logic [BW-1:0] bin_d [NB];
  logic [MW-1:0] mag;
  logic          start;

  fas_mag_sq u_mag (
    .bin_word (bin_q[idx_q]),
    .mag      (mag)
  );

  assign start = bus.fft_valid & ~fft_valid_dly_q;

  always_comb begin
    state_d         = state_q;
    fft_valid_dly_d = bus.fft_valid;
    idx_d           = idx_q;
    best_d          = best_q;
    freq_d          = freq_q;
    max_mag_d       = max_mag_q;
    done_d          = 1'b0;
    busy_d          = busy_q;
    bin_d           = bin_q;

    // A new frame overrides any scan or pending result, so the newest frame wins.
    if (start) begin
      bin_d     = bus.fft_d;
      idx_d     = '0;
      best_d    = '0;
      max_mag_d = '0;
      state_d   = ST_SCAN;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (mag > max_mag_q) begin
            max_mag_d = mag;
            best_d    = idx_q;
          end
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(NB - 1)) state_d = ST_DONE;
        end
        ST_DONE: begin
          freq_d  = best_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      fft_valid_dly_q <= 1'b0;
      idx_q           <= '0;
      best_q          <= '0;
      freq_q          <= '0;
      max_mag_q       <= '0;
      done_q          <= 1'b0;
      busy_q          <= 1'b0;
      bin_q           <= '{default: '0};
    end else begin
      state_q         <= state_d;
      fft_valid_dly_q <= fft_valid_dly_d;
      idx_q           <= idx_d;
      best_q          <= best_d;
      freq_q          <= freq_d;
      max_mag_q       <= max_mag_d;
      done_q          <= done_d;
      busy_q          <= busy_d;
      bin_q           <= bin_d;
    end
  end

  assign bus.done = done_q;
  assign bus.freq = freq_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_fas_freq_detect.sv
// Scoreboard bench for fas_freq_detect: each frame start pushes the expected
// peak index and done cycle; observed done pulses are popped and compared.
module tb_fas_freq_detect;
  import fas_freq_detect_pkg::*;

  typedef logic [31:0] frame_t [NB];
  typedef struct {
    logic [3:0]  freq;
    int unsigned cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fas_freq_detect_if bus ();

  fas_freq_detect dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  res_t obs_q[$];
  always @(negedge clk) if (bus.done === 1'b1) obs_q.push_back('{bus.freq, cyc});

  res_t        exp_q[$];
  int unsigned rd = 0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [3:0] ref_peak(input frame_t f);
    longint best_mag = -1;
    logic [3:0] best_k = '0;
    longint re, im, m;
    for (int k = 0; k < NB; k++) begin
      re = longint'($signed(f[k][31:16]));
      im = longint'($signed(f[k][15:0]));
      m  = re * re + im * im;
      if (m > best_mag) begin
        best_mag = m;
        best_k   = 4'(k);
      end
    end
    return best_k;
  endfunction

  // Drives a frame and raises fft_valid; a still-pending frame whose done edge
  // is not earlier than this start edge is aborted in the expectation model.
  task automatic start_frame(input frame_t f, input logic [3:0] ef);
    @(negedge clk);
    bus.fft_d = f;
    if (exp_q.size() > 0 && exp_q[$].cyc >= cyc + 1) void'(exp_q.pop_back());
    exp_q.push_back('{ef, cyc + 18});
    bus.fft_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.fft_valid = 1'b0;
    bus.fft_d = '{default: '0};
    repeat (3) @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.freq !== 4'd0) begin bad++; $display("FAIL reset_freq got=%0d exp=0", bus.freq); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frames();
    frame_t f[3];
    logic [3:0] ef[3];
    int nb;
    res_t e;
    for (int i = 0; i < 3; i++) f[i] = '{default: '0};
    f[0][5]  = 32'h0100_0000;                            ef[0] = 4'd5;
    f[1][3]  = 32'h0000_0200; f[1][9] = 32'hFE00_0000;   ef[1] = 4'd3;
    f[2][15] = 32'h8000_8000; f[2][0] = 32'h7FFF_7FFF;   ef[2] = 4'd15;
    for (int i = 0; i < 3; i++) begin
      start_frame(f[i], ef[i]);
      nb = 0;
      for (int c = 0; c < 22; c++) begin
        @(negedge clk);
        if (c == 0) bus.fft_valid = 1'b0;
        if (bus.busy === 1'b1) nb++;
      end
      total++; if (nb != 17) begin bad++; $display("FAIL busy_cycles frame=%0d got=%0d exp=17", i, nb); end
      while (rd < obs_q.size()) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL frames_spurious_done freq=%0d cyc=%0d", obs_q[rd].freq, obs_q[rd].cyc); end
        else begin
          e = exp_q.pop_front();
          if (obs_q[rd].freq !== e.freq || obs_q[rd].cyc != e.cyc) begin
            bad++; $display("FAIL frames_result got freq=%0d cyc=%0d exp freq=%0d cyc=%0d", obs_q[rd].freq, obs_q[rd].cyc, e.freq, e.cyc);
          end
        end
        rd++;
      end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL frames_missing_done pending=%0d exp=0", exp_q.size()); exp_q.delete(); end
      total++; if (bus.freq !== ef[i]) begin bad++; $display("FAIL frames_freq_hold got=%0d exp=%0d", bus.freq, ef[i]); end
    end
  endtask

  task automatic test_hold();
    frame_t f;
    int unsigned n0;
    res_t e;
    n0 = obs_q.size();
    f = '{default: '0}; f[4] = 32'h0030_0040;
    start_frame(f, 4'd4);
    repeat (100) @(negedge clk);
    total++; if (obs_q.size() - n0 != 1) begin bad++; $display("FAIL hold_single_done got=%0d exp=1", obs_q.size() - n0); end
    bus.fft_valid = 1'b0;
    f = '{default: '0}; f[12] = 32'hFF00_0010; f[4] = 32'h0001_0001;
    start_frame(f, 4'd12);
    repeat (25) @(negedge clk);
    bus.fft_valid = 1'b0;
    total++; if (obs_q.size() - n0 != 2) begin bad++; $display("FAIL hold_second_done got=%0d exp=2", obs_q.size() - n0); end
    while (rd < obs_q.size()) begin
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL hold_spurious_done freq=%0d cyc=%0d", obs_q[rd].freq, obs_q[rd].cyc); end
      else begin
        e = exp_q.pop_front();
        if (obs_q[rd].freq !== e.freq || obs_q[rd].cyc != e.cyc) begin
          bad++; $display("FAIL hold_result got freq=%0d cyc=%0d exp freq=%0d cyc=%0d", obs_q[rd].freq, obs_q[rd].cyc, e.freq, e.cyc);
        end
      end
      rd++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL hold_missing_done pending=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_abort();
    frame_t f;
    res_t e;
    f = '{default: '0}; f[2] = 32'h0400_0000;
    start_frame(f, 4'd2);
    @(negedge clk); bus.fft_valid = 1'b0;
    repeat (6) @(negedge clk);
    f = '{default: '0}; f[11] = 32'h0000_0300; f[2] = 32'h0001_0000;
    start_frame(f, 4'd11);
    @(negedge clk); bus.fft_valid = 1'b0;
    repeat (25) @(negedge clk);
    while (rd < obs_q.size()) begin
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL abort_spurious_done freq=%0d cyc=%0d", obs_q[rd].freq, obs_q[rd].cyc); end
      else begin
        e = exp_q.pop_front();
        if (obs_q[rd].freq !== e.freq || obs_q[rd].cyc != e.cyc) begin
          bad++; $display("FAIL abort_result got freq=%0d cyc=%0d exp freq=%0d cyc=%0d", obs_q[rd].freq, obs_q[rd].cyc, e.freq, e.cyc);
        end
      end
      rd++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL abort_missing_done pending=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  // Start on the exact DONE edge (aborts), then a start right after a done (both complete).
  task automatic test_back_to_back();
    frame_t f;
    res_t e;
    f = '{default: '0}; f[6] = 32'h0200_0200;
    start_frame(f, 4'd6);
    @(negedge clk); bus.fft_valid = 1'b0;
    repeat (15) @(negedge clk);
    f = '{default: '0}; f[1] = 32'h0050_0000;
    start_frame(f, 4'd1);
    @(negedge clk); bus.fft_valid = 1'b0;
    repeat (16) @(negedge clk);
    f = '{default: '0}; f[13] = 32'hFFF0_FFF0;
    start_frame(f, 4'd13);
    @(negedge clk); bus.fft_valid = 1'b0;
    repeat (22) @(negedge clk);
    while (rd < obs_q.size()) begin
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_spurious_done freq=%0d cyc=%0d", obs_q[rd].freq, obs_q[rd].cyc); end
      else begin
        e = exp_q.pop_front();
        if (obs_q[rd].freq !== e.freq || obs_q[rd].cyc != e.cyc) begin
          bad++; $display("FAIL b2b_result got freq=%0d cyc=%0d exp freq=%0d cyc=%0d", obs_q[rd].freq, obs_q[rd].cyc, e.freq, e.cyc);
        end
      end
      rd++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_missing_done pending=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_async_reset();
    frame_t f;
    res_t e;
    f = '{default: '0}; f[9] = 32'h0700_0000;
    start_frame(f, 4'd9);
    @(negedge clk); bus.fft_valid = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL areset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.freq !== 4'd0) begin bad++; $display("FAIL areset_freq got=%0d exp=0", bus.freq); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL areset_done got=%b exp=0", bus.done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    f = '{default: '0}; f[7] = 32'h0000_8000; f[8] = 32'h7FFF_0000;
    start_frame(f, 4'd7);
    @(negedge clk); bus.fft_valid = 1'b0;
    repeat (22) @(negedge clk);
    while (rd < obs_q.size()) begin
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL areset_spurious_done freq=%0d cyc=%0d", obs_q[rd].freq, obs_q[rd].cyc); end
      else begin
        e = exp_q.pop_front();
        if (obs_q[rd].freq !== e.freq || obs_q[rd].cyc != e.cyc) begin
          bad++; $display("FAIL areset_result got freq=%0d cyc=%0d exp freq=%0d cyc=%0d", obs_q[rd].freq, obs_q[rd].cyc, e.freq, e.cyc);
        end
      end
      rd++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL areset_missing_done pending=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_random();
    frame_t f;
    res_t e;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NB; k++) f[k] = $urandom();
      start_frame(f, ref_peak(f));
      @(negedge clk); bus.fft_valid = 1'b0;
      repeat (20) @(negedge clk);
    end
    while (rd < obs_q.size()) begin
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL random_spurious_done freq=%0d cyc=%0d", obs_q[rd].freq, obs_q[rd].cyc); end
      else begin
        e = exp_q.pop_front();
        if (obs_q[rd].freq !== e.freq || obs_q[rd].cyc != e.cyc) begin
          bad++; $display("FAIL random_result got freq=%0d cyc=%0d exp freq=%0d cyc=%0d", obs_q[rd].freq, obs_q[rd].cyc, e.freq, e.cyc);
        end
      end
      rd++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL random_missing_done pending=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_hold();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
